lade_speicher_einheit: RTL and testbench
========================================

Name: lade_speicher_einheit

Overview:
- Load/store unit directly downstream of the processor control FSM.
- Executes the memory access for load/store instructions while the controller sits in its WRITEBACK_LOAD / WRITEBACK_STORE states.
- Reports completion back to the controller via DatenGeladen / DatenGespeichert.
- Drives a word-oriented memory bus with request/ready handshake, byte masks and little-endian lane steering; produces sign/zero-extended load data for register writeback.

Parameters:
- ADRESS_BREITE, 32, byte address width (data width fixed at 32).

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- LoadDatenSignal  in  1  controller level request: perform load; held until DatenGeladen seen
- StoreDatenSignal  in  1  controller level request: perform store; held until DatenGespeichert seen
- Adresse  in  ADRESS_BREITE  byte address (ALU result)
- SchreibDaten  in  32  store source register value
- Funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- DatenGeladen  out  1  one-cycle pulse: load complete, LadeDaten valid
- DatenGespeichert  out  1  one-cycle pulse: store complete
- LadeDaten  out  32  extended load result, held until next load completes
- Fehlausrichtung  out  1  one-cycle pulse with done pulse when access was misaligned and not performed
- SpeicherAnfrage  out  1  bus request, held until accepted
- SpeicherSchreiben  out  1  1 = write, 0 = read; valid with SpeicherAnfrage
- SpeicherAdresse  out  ADRESS_BREITE  word-aligned address (bits [1:0] = 0)
- SpeicherSchreibDaten  out  32  lane-steered write data
- SpeicherByteMaske  out  4  active byte lanes (bit i = byte lane i)
- SpeicherBereit  in  1  slave accepts; on a read, SpeicherLeseDaten is valid in the same cycle
- SpeicherLeseDaten  in  32  read data

Behaviour:
- States: IDLE, ZUGRIFF0, ZUGRIFF1 (split second half, feature only), FERTIG.
- Reset: state IDLE. All outputs 0, including LadeDaten and SpeicherByteMaske. Reset mid-transaction drops SpeicherAnfrage at the next edge; slaves tolerate an abandoned request.
- IDLE:
  - On an edge sampling LoadDatenSignal or StoreDatenSignal high, capture Adresse, SchreibDaten, Funct3 and direction.
  - Load wins if both are high.
  - Go to ZUGRIFF0, or to FERTIG directly if misaligned without the feature.
  - Later input changes are ignored until the access completes.
- Alignment:
  - H/HU is misaligned when Adresse[0] = 1.
  - W is misaligned when Adresse[1:0] != 0.
  - B is never misaligned.
  - Funct3 011/110/111 are treated as W.
- ZUGRIFF0:
  - SpeicherAnfrage = 1; SpeicherAdresse = {addr[hi:2], 2'b00}.
  - Byte mask: B = 0001<<o, H = 0011<<o, W = 1111, where o = addr[1:0].
  - Store data shifted left by 8*o.
  - Stores take bits from SchreibDaten[7:0] for B and [15:0] for H.
  - Transfer completes in the cycle where SpeicherAnfrage && SpeicherBereit; go to FERTIG.
  - Load: select lanes from the shifted read data; sign-extend for B/H, zero-extend for BU/HU. Register into LadeDaten at that edge.
- FERTIG (exactly one cycle):
  - DatenGeladen or DatenGespeichert = 1 according to the direction.
  - Return to IDLE unconditionally.
  - Because the unit is in IDLE in the following cycle, the still-high request level from the controller is not re-sampled. The controller drops it at that edge.
- Latency: request high at edge k → SpeicherAnfrage in cycle k+1. With SpeicherBereit already high, the done pulse is in cycle k+2. Each wait cycle adds 1.
- Misaligned without feature:
  - No bus transaction; FERTIG is entered directly.
  - Fehlausrichtung = 1 together with the done pulse.
  - Load leaves LadeDaten = 0; store writes nothing.
- SpeicherSchreibDaten and SpeicherByteMaske are 0 whenever SpeicherAnfrage = 0.

Optional Feature:
- Macro: MISALIGNED_SPLIT_EN.
- When defined, a misaligned H/HU/W access becomes two bus transactions:
  - ZUGRIFF0 at the aligned word.
  - ZUGRIFF1 at that word + 4 (wraps modulo 2^ADRESS_BREITE).
- Write steering: the 64-bit value data<<(8*o) is split; low word to ZUGRIFF0, high word to ZUGRIFF1.
- Masks: 8-bit full-size mask<<o, split the same way.
- Load: first read word is buffered. Result = ({second, first} >> 8*o), truncated and extended.
- Fehlausrichtung never pulses when the feature is defined.
- When undefined, ZUGRIFF1 does not exist and the misaligned rule above applies.

Test Plan:
- Word load, Adresse=0x100, SpeicherBereit tied 1, read 0xDEADBEEF → SpeicherAdresse 0x100, mask 1111, DatenGeladen in cycle k+2, LadeDaten=0xDEADBEEF.
- LB at 0x103, read 0x80123456 → mask 1000, LadeDaten=0xFFFFFF80; LBU same → 0x00000080.
- SH at 0x202, SchreibDaten=0x0000ABCD, SpeicherBereit low 3 cycles → Anfrage held 4 cycles, mask 1100, SpeicherSchreibDaten=0xABCD0000, single DatenGespeichert pulse.
- LW at 0x301, feature off → no SpeicherAnfrage, DatenGeladen and Fehlausrichtung pulse together, LadeDaten=0.
- LW at 0x301, feature on, words 0x44332211 @0x300 and 0x88776655 @0x304:
  - Two requests, masks 1110 then 0001.
  - LadeDaten=0x55443322.
- Reset asserted while waiting in ZUGRIFF0 → SpeicherAnfrage 0 after next edge, no done pulse. Load and Store high together → load performed.

Source files
------------

// File: rtl/lade_speicher_einheit.sv
// Load/store unit: executes controller load/store requests on a word bus with byte lanes.
// Define MISALIGNED_SPLIT_EN to split misaligned H/HU/W accesses into two bus transfers.
module lade_speicher_einheit #(
    parameter int ADRESS_BREITE = 32
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     LoadDatenSignal,
    input  logic                     StoreDatenSignal,
    input  logic [ADRESS_BREITE-1:0] Adresse,
    input  logic [31:0]              SchreibDaten,
    input  logic [2:0]               Funct3,
    output logic                     DatenGeladen,
    output logic                     DatenGespeichert,
    output logic [31:0]              LadeDaten,
    output logic                     Fehlausrichtung,
    output logic                     SpeicherAnfrage,
    output logic                     SpeicherSchreiben,
    output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
    output logic [31:0]              SpeicherSchreibDaten,
    output logic [3:0]               SpeicherByteMaske,
    input  logic                     SpeicherBereit,
    input  logic [31:0]              SpeicherLeseDaten
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ZUGRIFF0 = 2'd1,
`ifdef MISALIGNED_SPLIT_EN
        ZUGRIFF1 = 2'd2,
`endif
        FERTIG   = 2'd3
    } zustand_t;

    function automatic logic istFehlausgerichtet(input logic [1:0] groesseCode,
                                                 input logic [1:0] o);
        logic r;
        case (groesseCode)
            2'b00:   r = 1'b0;
            2'b01:   r = o[0];
            default: r = (o != 2'b00);
        endcase
        return r;
    endfunction

    function automatic logic [3:0] groessenMaske(input logic [1:0] groesseCode);
        logic [3:0] m;
        case (groesseCode)
            2'b00:   m = 4'b0001;
            2'b01:   m = 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] speicherWertBilden(input logic [1:0]  groesseCode,
                                                       input logic [31:0] d);
        logic [31:0] w;
        case (groesseCode)
            2'b00:   w = {24'h0, d[7:0]};
            2'b01:   w = {16'h0, d[15:0]};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] erweitern(input logic [31:0] roh, input logic [2:0] f);
        logic [31:0] w;
        case (f[1:0])
            2'b00:   w = f[2] ? {24'h0, roh[7:0]}  : {{24{roh[7]}}, roh[7:0]};
            2'b01:   w = f[2] ? {16'h0, roh[15:0]} : {{16{roh[15]}}, roh[15:0]};
            default: w = roh;
        endcase
        return w;
    endfunction

    zustand_t                 zustand, zustandNaechst;
    logic [ADRESS_BREITE-1:0] adrReg;
    logic [31:0]              datenReg;
    logic [2:0]               funct3Reg;
    logic                     ladenReg;
    logic                     fehlReg;

    logic                     uebernehmen;
    logic                     anfrageFehl;
    logic [1:0]               versatz;
    logic [4:0]               bitVersatz;
    logic [ADRESS_BREITE-3:0] wortAdr;
    logic [3:0]               groesse;
    logic [31:0]              speicherWert;
    logic [31:0]              leseWert;
    logic                     ladeSchreiben;
    logic [31:0]              ladeWert;

`ifdef MISALIGNED_SPLIT_EN
    logic [63:0]              breitDaten;
    logic [7:0]               breitMaske;
    logic [63:0]              leseQuelle;
    logic [31:0]              erstesWort;
    logic                     erstesWortSchreiben;
`else
    logic [31:0]              schreibWort;
    logic [3:0]               maskeWort;
`endif

    assign uebernehmen  = LoadDatenSignal || StoreDatenSignal;
    assign anfrageFehl  = istFehlausgerichtet(Funct3[1:0], Adresse[1:0]);
    assign versatz      = adrReg[1:0];
    assign bitVersatz   = {versatz, 3'b000};
    assign wortAdr      = adrReg[ADRESS_BREITE-1:2];
    assign groesse      = groessenMaske(funct3Reg[1:0]);
    assign speicherWert = speicherWertBilden(funct3Reg[1:0], datenReg);

`ifdef MISALIGNED_SPLIT_EN
    // Lanes are steered across a 64-bit window spanning the addressed word and the next one
    assign breitDaten = {32'h0, speicherWert} << bitVersatz;
    assign breitMaske = {4'h0, groesse} << versatz;
    assign leseQuelle = (zustand == ZUGRIFF1) ? {SpeicherLeseDaten, erstesWort}
                                              : {32'h0, SpeicherLeseDaten};
    assign leseWert   = erweitern(32'(leseQuelle >> bitVersatz), funct3Reg);
`else
    assign schreibWort = speicherWert << bitVersatz;
    assign maskeWort   = groesse << versatz;
    assign leseWert    = erweitern(SpeicherLeseDaten >> bitVersatz, funct3Reg);
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            zustand    <= IDLE;
            adrReg     <= '0;
            datenReg   <= '0;
            funct3Reg  <= '0;
            ladenReg   <= 1'b0;
            fehlReg    <= 1'b0;
            LadeDaten  <= '0;
`ifdef MISALIGNED_SPLIT_EN
            erstesWort <= '0;
`endif
        end else begin
            zustand <= zustandNaechst;
            if (zustand == IDLE && uebernehmen) begin
                adrReg    <= Adresse;
                datenReg  <= SchreibDaten;
                funct3Reg <= Funct3;
                ladenReg  <= LoadDatenSignal;
                fehlReg   <= anfrageFehl;
            end
            if (ladeSchreiben) begin
                LadeDaten <= ladeWert;
            end
`ifdef MISALIGNED_SPLIT_EN
            if (erstesWortSchreiben) begin
                erstesWort <= SpeicherLeseDaten;
            end
`endif
        end
    end

    always_comb begin
        zustandNaechst       = zustand;
        DatenGeladen         = 1'b0;
        DatenGespeichert     = 1'b0;
        Fehlausrichtung      = 1'b0;
        SpeicherAnfrage      = 1'b0;
        SpeicherSchreiben    = 1'b0;
        SpeicherAdresse      = '0;
        SpeicherSchreibDaten = '0;
        SpeicherByteMaske    = '0;
        ladeSchreiben        = 1'b0;
        ladeWert             = '0;
`ifdef MISALIGNED_SPLIT_EN
        erstesWortSchreiben  = 1'b0;
`endif
        case (zustand)
            IDLE: begin
                if (uebernehmen) begin
`ifdef MISALIGNED_SPLIT_EN
                    zustandNaechst = ZUGRIFF0;
`else
                    zustandNaechst = anfrageFehl ? FERTIG : ZUGRIFF0;
                    // an abandoned misaligned load reports a zero result
                    ladeSchreiben  = anfrageFehl && LoadDatenSignal;
`endif
                end
            end
            ZUGRIFF0: begin
                SpeicherAnfrage   = 1'b1;
                SpeicherSchreiben = !ladenReg;
                SpeicherAdresse   = {wortAdr, 2'b00};
`ifdef MISALIGNED_SPLIT_EN
                SpeicherByteMaske    = breitMaske[3:0];
                SpeicherSchreibDaten = ladenReg ? '0 : breitDaten[31:0];
                if (SpeicherBereit) begin
                    erstesWortSchreiben = 1'b1;
                    if (fehlReg) begin
                        zustandNaechst = ZUGRIFF1;
                    end else begin
                        zustandNaechst = FERTIG;
                        ladeSchreiben  = ladenReg;
                        ladeWert       = leseWert;
                    end
                end
`else
                SpeicherByteMaske    = maskeWort;
                SpeicherSchreibDaten = ladenReg ? '0 : schreibWort;
                if (SpeicherBereit) begin
                    zustandNaechst = FERTIG;
                    ladeSchreiben  = ladenReg;
                    ladeWert       = leseWert;
                end
`endif
            end
`ifdef MISALIGNED_SPLIT_EN
            ZUGRIFF1: begin
                SpeicherAnfrage      = 1'b1;
                SpeicherSchreiben    = !ladenReg;
                SpeicherAdresse      = {wortAdr + (ADRESS_BREITE-2)'(1), 2'b00};
                SpeicherByteMaske    = breitMaske[7:4];
                SpeicherSchreibDaten = ladenReg ? '0 : breitDaten[63:32];
                if (SpeicherBereit) begin
                    zustandNaechst = FERTIG;
                    ladeSchreiben  = ladenReg;
                    ladeWert       = leseWert;
                end
            end
`endif
            FERTIG: begin
                DatenGeladen     = ladenReg;
                DatenGespeichert = !ladenReg;
`ifndef MISALIGNED_SPLIT_EN
                Fehlausrichtung  = fehlReg;
`endif
                zustandNaechst   = IDLE;
            end
            default: zustandNaechst = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lade_speicher_einheit.sv
// Scoreboard bench for lade_speicher_einheit: byte-level memory model predicts bus beats and results.
`timescale 1ns/1ps
module tb_lade_speicher_einheit;

    localparam int AB = 32;

    logic          Clock;
    logic          Reset;
    logic          LoadDatenSignal;
    logic          StoreDatenSignal;
    logic [AB-1:0] Adresse;
    logic [31:0]   SchreibDaten;
    logic [2:0]    Funct3;
    logic          DatenGeladen;
    logic          DatenGespeichert;
    logic [31:0]   LadeDaten;
    logic          Fehlausrichtung;
    logic          SpeicherAnfrage;
    logic          SpeicherSchreiben;
    logic [AB-1:0] SpeicherAdresse;
    logic [31:0]   SpeicherSchreibDaten;
    logic [3:0]    SpeicherByteMaske;
    logic          SpeicherBereit    = 1'b0;
    logic [31:0]   SpeicherLeseDaten = 32'h0;

    lade_speicher_einheit #(.ADRESS_BREITE(AB)) dut (
        .Clock                (Clock),
        .Reset                (Reset),
        .LoadDatenSignal      (LoadDatenSignal),
        .StoreDatenSignal     (StoreDatenSignal),
        .Adresse              (Adresse),
        .SchreibDaten         (SchreibDaten),
        .Funct3               (Funct3),
        .DatenGeladen         (DatenGeladen),
        .DatenGespeichert     (DatenGespeichert),
        .LadeDaten            (LadeDaten),
        .Fehlausrichtung      (Fehlausrichtung),
        .SpeicherAnfrage      (SpeicherAnfrage),
        .SpeicherSchreiben    (SpeicherSchreiben),
        .SpeicherAdresse      (SpeicherAdresse),
        .SpeicherSchreibDaten (SpeicherSchreibDaten),
        .SpeicherByteMaske    (SpeicherByteMaske),
        .SpeicherBereit       (SpeicherBereit),
        .SpeicherLeseDaten    (SpeicherLeseDaten)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  maske;
        logic        schreiben;
        logic [31:0] daten;
    } beat_t;

    typedef struct {
        logic        laden;
        logic        fehl;
        logic [31:0] wert;
    } fertig_t;

    beat_t       erwBeats[$];
    fertig_t     erwFertig[$];
    logic [7:0]  refMem [logic [31:0]];
    logic [7:0]  slvMem [logic [31:0]];
    int          anzahl = 0;
    int          fehler = 0;
    int          bereitProzent = 100;
    int          warteRest = 0;

    task automatic pruefe(input string name, input logic [31:0] ist, input logic [31:0] soll);
        anzahl++;
        if (ist !== soll) begin
            fehler++;
            $display("FAIL %s: ist=0x%08h soll=0x%08h", name, ist, soll);
        end
    endtask

    function automatic logic [7:0] startByte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'd2654435761;
        return h[31:24];
    endfunction

    function automatic logic [7:0] refLesen(input logic [31:0] a);
        return refMem.exists(a) ? refMem[a] : startByte(a);
    endfunction

    function automatic logic [7:0] slvLesen(input logic [31:0] a);
        return slvMem.exists(a) ? slvMem[a] : startByte(a);
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int j = 0; j < 4; j++) if (m[j]) r[8*j +: 8] = 8'hFF;
        return r;
    endfunction

    task automatic setzeWort(input logic [31:0] a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) begin
            refMem[a + 32'(j)] = w[8*j +: 8];
            slvMem[a + 32'(j)] = w[8*j +: 8];
        end
    endtask

    // Slave: wait states and read data settle shortly after each rising edge
    always @(posedge Clock) begin
        #1;
        if (SpeicherAnfrage && warteRest > 0) begin
            SpeicherBereit = 1'b0;
            warteRest--;
        end else if (SpeicherAnfrage) begin
            SpeicherBereit = ($urandom_range(99) < 32'(bereitProzent));
        end else begin
            SpeicherBereit = 1'($urandom_range(1));
        end
        for (int j = 0; j < 4; j++) SpeicherLeseDaten[8*j +: 8] = slvLesen(SpeicherAdresse + 32'(j));
    end

    always @(negedge Clock) begin
        if (SpeicherAnfrage && SpeicherBereit && SpeicherSchreiben)
            for (int j = 0; j < 4; j++)
                if (SpeicherByteMaske[j]) slvMem[SpeicherAdresse + 32'(j)] = SpeicherSchreibDaten[8*j +: 8];
    end

    beat_t   mb;
    fertig_t mf;
    always @(negedge Clock) begin
        if (!Reset) begin
            if (SpeicherAnfrage && SpeicherBereit) begin
                if (erwBeats.size() == 0) begin
                    anzahl++;
                    fehler++;
                    $display("FAIL unerwarteter_buszugriff: ist adr=0x%08h soll kein Zugriff", SpeicherAdresse);
                end else begin
                    mb = erwBeats.pop_front();
                    pruefe("bus_adresse", SpeicherAdresse, mb.adr);
                    pruefe("bus_maske", 32'(SpeicherByteMaske), 32'(mb.maske));
                    pruefe("bus_schreiben", 32'(SpeicherSchreiben), 32'(mb.schreiben));
                    if (mb.schreiben) pruefe("bus_daten", SpeicherSchreibDaten & lanes(mb.maske), mb.daten);
                end
            end
            if (!SpeicherAnfrage) begin
                pruefe("ruhe_schreibdaten", SpeicherSchreibDaten, 32'h0);
                pruefe("ruhe_maske", 32'(SpeicherByteMaske), 32'h0);
            end
            if (DatenGeladen || DatenGespeichert) begin
                if (erwFertig.size() == 0) begin
                    anzahl++;
                    fehler++;
                    $display("FAIL unerwartetes_fertig: ist geladen=%0b gespeichert=%0b soll kein Puls",
                             DatenGeladen, DatenGespeichert);
                end else begin
                    mf = erwFertig.pop_front();
                    pruefe("fertig_richtung", 32'({DatenGeladen, DatenGespeichert}), mf.laden ? 32'h2 : 32'h1);
                    pruefe("fehlausrichtung", 32'(Fehlausrichtung), 32'(mf.fehl));
                    if (mf.laden) pruefe("lade_daten", LadeDaten, mf.wert);
                    pruefe("beats_offen_bei_fertig", erwBeats.size(), 0);
                end
            end else begin
                pruefe("fehl_ohne_fertig", 32'(Fehlausrichtung), 32'h0);
            end
        end
    end

    task automatic zugriff(input logic laden, input logic beide, input logic [31:0] adr,
                           input logic [31:0] daten, input logic [2:0] f3, input int warten);
        int          n;
        int          latenz;
        logic        gesehen;
        logic        offen;
        beat_t       b;
        beat_t       liste[$];
        fertig_t     e;
        logic [31:0] wert;
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        e.laden = laden;
        e.fehl  = 1'b0;
        e.wert  = 32'h0;
`ifndef MISALIGNED_SPLIT_EN
        e.fehl  = ((adr % 32'(n)) != 0);
`endif
        wert  = 32'h0;
        offen = 1'b0;
        if (!e.fehl) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] ba;
                int          lane;
                ba   = adr + 32'(i);
                lane = int'(ba[1:0]);
                if (offen && b.adr != (ba & ~32'h3)) begin
                    liste.push_back(b);
                    offen = 1'b0;
                end
                if (!offen) begin
                    b.adr       = ba & ~32'h3;
                    b.maske     = 4'h0;
                    b.schreiben = !laden;
                    b.daten     = 32'h0;
                    offen       = 1'b1;
                end
                b.maske[lane] = 1'b1;
                if (laden) begin
                    wert[8*i +: 8] = refLesen(ba);
                end else begin
                    b.daten[8*lane +: 8] = daten[8*i +: 8];
                    refMem[ba] = daten[8*i +: 8];
                end
            end
            if (offen) liste.push_back(b);
            if (n == 1 && !f3[2]) wert = {{24{wert[7]}}, wert[7:0]};
            if (n == 2 && !f3[2]) wert = {{16{wert[15]}}, wert[15:0]};
            e.wert = wert;
        end
        foreach (liste[k]) erwBeats.push_back(liste[k]);
        erwFertig.push_back(e);

        @(negedge Clock);
        warteRest        = warten;
        Adresse          = adr;
        SchreibDaten     = daten;
        Funct3           = f3;
        LoadDatenSignal  = laden;
        StoreDatenSignal = !laden || beide;
        latenz  = 0;
        gesehen = 1'b0;
        while (!gesehen && latenz < 200) begin
            @(negedge Clock);
            latenz++;
            Adresse      = $urandom;
            SchreibDaten = $urandom;
            Funct3       = 3'($urandom_range(7));
            if (DatenGeladen || DatenGespeichert) gesehen = 1'b1;
        end
        pruefe("fertig_zeitlimit", 32'(gesehen), 32'h1);
        if (bereitProzent == 100)
            pruefe("latenz", latenz, 1 + liste.size() + ((liste.size() > 0) ? warten : 0));
        @(posedge Clock);
        #1;
        LoadDatenSignal  = 1'b0;
        StoreDatenSignal = 1'b0;
    endtask

    initial begin
        logic [31:0] zAdr;
        Reset            = 1'b1;
        LoadDatenSignal  = 1'b0;
        StoreDatenSignal = 1'b0;
        Adresse          = '0;
        SchreibDaten     = '0;
        Funct3           = '0;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        pruefe("reset_geladen", 32'(DatenGeladen), 32'h0);
        pruefe("reset_gespeichert", 32'(DatenGespeichert), 32'h0);
        pruefe("reset_ladedaten", LadeDaten, 32'h0);
        pruefe("reset_fehl", 32'(Fehlausrichtung), 32'h0);
        pruefe("reset_anfrage", 32'(SpeicherAnfrage), 32'h0);
        pruefe("reset_schreiben", 32'(SpeicherSchreiben), 32'h0);
        pruefe("reset_adresse", SpeicherAdresse, 32'h0);
        pruefe("reset_maske", 32'(SpeicherByteMaske), 32'h0);
        Reset = 1'b0;

        setzeWort(32'h100, 32'hDEADBEEF);
        zugriff(1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 0);
        pruefe("lw_0x100", LadeDaten, 32'hDEADBEEF);

        setzeWort(32'h100, 32'h80123456);
        zugriff(1'b1, 1'b0, 32'h103, 32'h0, 3'b000, 0);
        pruefe("lb_0x103", LadeDaten, 32'hFFFFFF80);
        zugriff(1'b1, 1'b0, 32'h103, 32'h0, 3'b100, 0);
        pruefe("lbu_0x103", LadeDaten, 32'h00000080);

        setzeWort(32'h200, 32'h11223344);
        zugriff(1'b0, 1'b0, 32'h202, 32'h0000ABCD, 3'b001, 3);
        zAdr = 32'h202;
        pruefe("sh_0x202_speicher", {slvLesen(zAdr + 32'h1), slvLesen(zAdr), slvLesen(zAdr - 32'h1), slvLesen(zAdr - 32'h2)},
               32'hABCD3344);

        setzeWort(32'h300, 32'h44332211);
        setzeWort(32'h304, 32'h88776655);
        zugriff(1'b1, 1'b0, 32'h301, 32'h0, 3'b010, 0);
`ifdef MISALIGNED_SPLIT_EN
        pruefe("lw_0x301_geteilt", LadeDaten, 32'h55443322);
`else
        pruefe("lw_0x301_fehl", LadeDaten, 32'h0);
`endif

        zugriff(1'b1, 1'b1, 32'h100, 32'h12345678, 3'b010, 0);
        pruefe("load_vor_store", LadeDaten, 32'h80123456);

        zugriff(1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 3'b001, 1);
        zugriff(1'b0, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, 3'b010, 0);

        // Reset while the bus request waits for the slave
        @(negedge Clock);
        warteRest       = 1000;
        Adresse         = 32'h100;
        Funct3          = 3'b010;
        LoadDatenSignal = 1'b1;
        @(negedge Clock);
        pruefe("anfrage_vor_reset", 32'(SpeicherAnfrage), 32'h1);
        Reset           = 1'b1;
        LoadDatenSignal = 1'b0;
        @(posedge Clock);
        #1;
        pruefe("anfrage_nach_reset", 32'(SpeicherAnfrage), 32'h0);
        pruefe("ladedaten_nach_reset", LadeDaten, 32'h0);
        warteRest = 0;
        @(negedge Clock);
        Reset = 1'b0;
        repeat (4) @(negedge Clock);

        bereitProzent = 60;
        for (int t = 0; t < 300; t++) begin
            logic [31:0] a;
            a = ($urandom_range(3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(7)))
                                         : (32'h1000 + 32'($urandom_range(63)));
            zugriff(1'($urandom_range(1)), 1'($urandom_range(3) == 0), a, $urandom,
                    3'($urandom_range(7)), int'($urandom_range(2)));
        end

        repeat (5) @(negedge Clock);
        pruefe("beats_rest", erwBeats.size(), 0);
        pruefe("fertig_rest", erwFertig.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", anzahl, fehler);
        $finish;
    end

endmodule
